// File: rtl/shape_pkg.sv
// Shared types and default sizing for the shape unit's magnitude scan.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package shape_pkg;

    localparam int SHAPE_W       = 32;
    localparam int SHAPE_IDX_W   = 8;
    localparam int SHAPE_MAX_LEN = 256;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_DRAIN,
        S_DONE
    } scan_state_t;

    // One candidate in the scan: raw signed value, its magnitude and list position.
    typedef struct packed {
        logic [SHAPE_W-1:0]     val;
        logic [SHAPE_W-1:0]     mag;
        logic [SHAPE_IDX_W-1:0] idx;
    } mag_entry_t;

endpackage

// File: rtl/mag_cmp.sv
// Two's-complement magnitude of a and b, plus unsigned |a| > |b|.
// Latency: combinational.
// Backpressure: none.
module mag_cmp #(
    parameter int W = 32
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] mag_a,
    output logic [W-1:0] mag_b,
    output logic         gt
);

    // Magnitudes are unsigned W-bit, so the most negative value maps to 2**(W-1)
    // and correctly beats the most positive value.
    always_comb begin
        mag_a = a[W-1] ? (~a + W'(1)) : a;
        mag_b = b[W-1] ? (~b + W'(1)) : b;
        gt    = (mag_a > mag_b);
    end

endmodule

// File: rtl/abs_max_scan.sv
// Scans a list of signed elements and returns the one with the largest |value|.
// Latency: last element accepted at t -> res_valid at t+2; one element per cycle in SCAN.
// Backpressure: in_ready only in SCAN; result held until res_ready, then back to IDLE.
module abs_max_scan
    import shape_pkg::*;
#(
    parameter int W       = SHAPE_W,
    parameter int IDX_W   = SHAPE_IDX_W,
    parameter int MAX_LEN = SHAPE_MAX_LEN
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_data,
    input  logic             in_last,
    output logic             busy,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [W-1:0]     res_value,
    output logic [W-1:0]     res_mag,
    output logic [IDX_W-1:0] res_index,
    output logic             res_err
);

    localparam logic [IDX_W-1:0] LAST_CNT = IDX_W'(MAX_LEN - 1);

    scan_state_t state_q, state_d;

    logic [IDX_W-1:0] count_q;
    logic             err_q;

    // Stage register S1: the element accepted last cycle
    logic             s1_vld;
    logic [W-1:0]     s1_val;
    logic [IDX_W-1:0] s1_idx;

    // Running winner
    logic             best_vld;
    logic [W-1:0]     best_val;
    logic [IDX_W-1:0] best_idx;

    logic [W-1:0]     s1_mag;
    logic [W-1:0]     best_mag;
    logic             s1_gt;
    logic             take;
    logic             accept;
    logic             at_cap;
    logic             end_list;

    logic [W-1:0]     nxt_val;
    logic [W-1:0]     nxt_mag;
    logic [IDX_W-1:0] nxt_idx;

    assign accept   = in_valid && (state_q == S_SCAN);
    assign at_cap   = (count_q == LAST_CNT);
    // A list ends on in_last, or is cut off when the capacity is reached.
    assign end_list = accept && (in_last || at_cap);

    // Single shared comparator: staged element versus current best.
    mag_cmp #(.W(W)) u_mag_cmp (
        .a     (s1_val),
        .b     (best_val),
        .mag_a (s1_mag),
        .mag_b (best_mag),
        .gt    (s1_gt)
    );

    // Strictly greater only, so ties keep the earlier index.
    always_comb begin
        take    = s1_vld && (!best_vld || s1_gt);
        nxt_val = take ? s1_val : best_val;
        nxt_mag = take ? s1_mag : best_mag;
        nxt_idx = take ? s1_idx : best_idx;
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and state-decoded handshake outputs
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        busy      = 1'b1;
        res_valid = 1'b0;
        case (state_q)
            S_IDLE: begin
                busy = 1'b0;
                if (start) state_d = S_SCAN;
            end
            S_SCAN: begin
                in_ready = 1'b1;
                if (end_list) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                state_d = S_DONE;
            end
            S_DONE: begin
                res_valid = 1'b1;
                if (res_ready) state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Element counter, S1 staging, running best and truncation flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q  <= '0;
            err_q    <= 1'b0;
            s1_vld   <= 1'b0;
            s1_val   <= '0;
            s1_idx   <= '0;
            best_vld <= 1'b0;
            best_val <= '0;
            best_idx <= '0;
        end else if (state_q == S_IDLE && start) begin
            count_q  <= '0;
            err_q    <= 1'b0;
            s1_vld   <= 1'b0;
            best_vld <= 1'b0;
            best_val <= '0;
            best_idx <= '0;
        end else begin
            s1_vld <= accept;
            if (accept) begin
                s1_val  <= in_data;
                s1_idx  <= count_q;
                count_q <= count_q + IDX_W'(1);
            end
            if (end_list && !in_last) begin
                err_q <= 1'b1;
            end
            if (take) begin
                best_vld <= 1'b1;
                best_val <= s1_val;
                best_idx <= s1_idx;
            end
        end
    end

    // Result registers load the post-compare winner during the drain cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_value <= '0;
            res_mag   <= '0;
            res_index <= '0;
            res_err   <= 1'b0;
        end else if (state_q == S_IDLE && start) begin
            res_err <= 1'b0;
        end else if (state_q == S_DRAIN) begin
            res_value <= nxt_val;
            res_mag   <= nxt_mag;
            res_index <= nxt_idx;
            res_err   <= err_q;
        end
    end

endmodule
